// File: rtl/my_gates_pkg.sv
// rtl/my_gates_pkg.sv - shared types and sizing helpers for the arbitrating mux
package my_gates_pkg;

  typedef enum logic {ARB_FIXED, ARB_RR} arb_mode_t;

  localparam int DEFAULT_WIDTH = 16;

  // A single channel still needs a one-bit index field.
  function automatic int chan_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/my_rr_arbiter.sv
// rtl/my_rr_arbiter.sv - fixed-priority / round-robin arbiter with one-hot and encoded grant
module my_rr_arbiter
  import my_gates_pkg::*;
#(
  parameter int        N    = 8,
  parameter arb_mode_t MODE = ARB_RR,
  localparam int       CW   = chan_w(N)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [N-1:0]  req,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [CW-1:0] gnt_idx
);

  logic [CW-1:0] r_ptr;
  logic          w_found;
  logic [CW-1:0] w_idx;

  // Fixed priority is the same upward search with the pointer pinned at 0.
  always_comb begin : p_search
    int            k;
    logic [CW-1:0] kk;
    w_found = 1'b0;
    w_idx   = '0;
    k       = 0;
    kk      = '0;
    for (int i = 0; i < N; i++) begin
      k = int'(r_ptr) + i;
      if (k >= N) k = k - N;
      kk = CW'(k);
      if (!w_found && req[kk]) begin
        w_found = 1'b1;
        w_idx   = kk;
      end
    end
  end

  assign gnt     = (en && w_found) ? ({{(N-1){1'b0}}, 1'b1} << w_idx) : '0;
  assign gnt_idx = w_idx;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr <= '0;
    end else if (MODE == ARB_RR && en && w_found) begin
      r_ptr <= (w_idx == CW'(N - 1)) ? '0 : w_idx + 1'b1;
    end
  end

endmodule

// File: rtl/my_arb_mux_nway16.sv
// rtl/my_arb_mux_nway16.sv - N-way arbitrating mux into a one-entry registered output
module my_arb_mux_nway16
  import my_gates_pkg::*;
#(
  parameter int        WIDTH  = DEFAULT_WIDTH,
  parameter int        N      = 8,
  parameter arb_mode_t MODE   = ARB_RR,
  localparam int       CHAN_W = chan_w(N)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [N-1:0][WIDTH-1:0]   in_data,
  input  logic [N-1:0]              in_valid,
  output logic [N-1:0]              in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [CHAN_W-1:0]         out_chan,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_and,
  output logic                      out_or
);

  logic [WIDTH-1:0]  r_data;
  logic [CHAN_W-1:0] r_chan;
  logic              r_valid;
  logic              r_and;
  logic              r_or;

  logic              w_can_load;
  logic [N-1:0]      w_gnt;
  logic [CHAN_W-1:0] w_gnt_idx;
  logic              w_xfer;
  logic [WIDTH-1:0]  w_sel;

  // Gating with reset_n keeps every in_ready low while reset is held.
  assign w_can_load = reset_n && (!r_valid || out_ready);

  my_rr_arbiter #(
    .N    (N),
    .MODE (MODE)
  ) u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (in_valid),
    .en      (w_can_load),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx)
  );

  assign in_ready = w_gnt;
  assign w_xfer   = |(in_valid & w_gnt);
  assign w_sel    = in_data[w_gnt_idx];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data  <= '0;
      r_chan  <= '0;
      r_valid <= 1'b0;
      r_and   <= 1'b0;
      r_or    <= 1'b0;
    end else if (w_xfer) begin
      r_data  <= w_sel;
      r_chan  <= w_gnt_idx;
      r_valid <= 1'b1;
      r_and   <= &w_sel;
      r_or    <= |w_sel;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_data  = r_data;
  assign out_chan  = r_chan;
  assign out_valid = r_valid;
  assign out_and   = r_and;
  assign out_or    = r_or;

endmodule

// File: tb/tb_my_arb_mux_nway16.sv
// tb/tb_my_arb_mux_nway16.sv - self-checking bench for the round-robin and fixed-priority muxes
module tb_my_arb_mux_nway16;
  import my_gates_pkg::*;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [15:0]      d [8];
  logic [7:0][15:0] in_data;

  logic [7:0]  rr_valid, rr_iready, fx_valid, fx_iready;
  logic        rr_oready, fx_oready;
  logic [15:0] rr_odata, fx_odata;
  logic [2:0]  rr_ochan, fx_ochan;
  logic        rr_ovalid, fx_ovalid, rr_oand, fx_oand, rr_oor, fx_oor;

  typedef struct {
    logic [2:0]  chan;
    logic [15:0] data;
  } exp_t;

  typedef struct {
    logic [7:0] valid;
    logic       ordy;
    logic [7:0] exp_ready;
  } vec_t;

  exp_t sb_q[$];
  vec_t rr_tbl[10];
  vec_t fx_tbl[6];
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < 8; i++) in_data[i] = d[i];
  end

  my_arb_mux_nway16 #(.WIDTH(16), .N(8), .MODE(ARB_RR)) u_rr (
    .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(rr_valid),
    .in_ready(rr_iready), .out_data(rr_odata), .out_chan(rr_ochan),
    .out_valid(rr_ovalid), .out_ready(rr_oready), .out_and(rr_oand), .out_or(rr_oor)
  );

  my_arb_mux_nway16 #(.WIDTH(16), .N(8), .MODE(ARB_FIXED)) u_fx (
    .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(fx_valid),
    .in_ready(fx_iready), .out_data(fx_odata), .out_chan(fx_ochan),
    .out_valid(fx_ovalid), .out_ready(fx_oready), .out_and(fx_oand), .out_or(fx_oor)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    else n_pass++;
  endtask

  function automatic logic [2:0] oh2idx(input logic [7:0] v);
    logic [2:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) if (v[i]) r = 3'(i);
    return r;
  endfunction

  // Drive one cycle, check the grant, queue the expected word, check it after the edge.
  task automatic cycle(input bit fx, input logic [7:0] v, input logic ordy,
                       input logic [7:0] er, input string nm);
    exp_t e;
    bit   pushed;
    if (fx) begin fx_valid = v; fx_oready = ordy; end
    else begin rr_valid = v; rr_oready = ordy; end
    #1;
    chk({nm, "_in_ready"}, fx ? fx_iready : rr_iready, er);
    pushed = (er != 8'h00);
    if (pushed) begin
      e.chan = oh2idx(er);
      e.data = d[e.chan];
      sb_q.push_back(e);
    end
    @(posedge clk); #1;
    if (pushed) begin
      e = sb_q.pop_front();
      chk({nm, "_out_valid"}, fx ? fx_ovalid : rr_ovalid, 1);
      chk({nm, "_out_chan"},  fx ? fx_ochan  : rr_ochan,  e.chan);
      chk({nm, "_out_data"},  fx ? fx_odata  : rr_odata,  e.data);
      chk({nm, "_out_and"},   fx ? fx_oand   : rr_oand,   &e.data);
      chk({nm, "_out_or"},    fx ? fx_oor    : rr_oor,    |e.data);
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) d[i] = 16'hA500 | 16'(i * 17);
    for (int k = 0; k < 10; k++) rr_tbl[k] = '{8'hFF, 1'b1, 8'(1 << (k % 8))};
    for (int k = 0; k < 4; k++)  fx_tbl[k] = '{8'b1010_0100, 1'b1, 8'h04};
    for (int k = 4; k < 6; k++)  fx_tbl[k] = '{8'b1010_0000, 1'b1, 8'h20};

    reset_n   = 1'b0;
    rr_valid  = 8'hFF;
    rr_oready = 1'b1;
    fx_valid  = 8'h00;
    fx_oready = 1'b1;

    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("reset_out_valid", rr_ovalid, 0);
      chk("reset_out_data",  rr_odata,  0);
      chk("reset_in_ready",  rr_iready, 0);
    end
    reset_n = 1'b1;
    #1;
    chk("post_reset_in_ready", rr_iready, 8'h01);

    for (int k = 0; k < 10; k++)
      cycle(1'b0, rr_tbl[k].valid, rr_tbl[k].ordy, rr_tbl[k].exp_ready, "rr_fair");

    // Backpressure: FULL holding channel 1, pointer sits at 2.
    d[3]      = 16'hFFFF;
    rr_oready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("stall_in_ready", rr_iready, 0);
      @(posedge clk); #1;
      chk("stall_out_valid", rr_ovalid, 1);
      chk("stall_out_chan",  rr_ochan,  1);
      chk("stall_out_data",  rr_odata,  d[1]);
    end
    cycle(1'b0, 8'hFF, 1'b1, 8'h04, "unstall");
    cycle(1'b0, 8'hFF, 1'b1, 8'h08, "ch3_ones");

    d[2] = 16'hFFFF;
    cycle(1'b0, 8'h04, 1'b1, 8'h04, "red_ones");
    d[2] = 16'h0000;
    cycle(1'b0, 8'h04, 1'b1, 8'h04, "red_zero");

    cycle(1'b0, 8'h00, 1'b1, 8'h00, "drain");
    chk("drain_out_valid", rr_ovalid, 0);
    chk("drain_out_chan",  rr_ochan,  2);
    chk("drain_out_data",  rr_odata,  16'h0000);

    cycle(1'b0, 8'h40, 1'b1, 8'h40, "pre_wrap");
    cycle(1'b0, 8'h81, 1'b1, 8'h80, "wrap7");
    cycle(1'b0, 8'h81, 1'b1, 8'h01, "wrap0");

    rr_oready = 1'b0;
    for (int k = 0; k < 6; k++)
      cycle(1'b1, fx_tbl[k].valid, fx_tbl[k].ordy, fx_tbl[k].exp_ready, "fixed");

    // Asynchronous reset while FULL, away from any clock edge.
    chk("pre_areset_full", rr_ovalid, 1);
    #3;
    reset_n = 1'b0;
    #1;
    chk("areset_out_valid", rr_ovalid, 0);
    chk("areset_out_data",  rr_odata,  0);
    chk("areset_out_chan",  rr_ochan,  0);
    chk("areset_in_ready",  rr_iready, 0);
    chk("areset_fx_valid",  fx_ovalid, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    cycle(1'b0, 8'h81, 1'b1, 8'h01, "ptr_cleared");

    chk("sb_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
